// File: rtl/sha_pkg.sv
// Shared types, constants and byte-lane helpers for the SHA-256 message padder.
package sha_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAD   = 2'd1,
    EMIT  = 2'd2,
    EXTRA = 2'd3
  } state_e;

  typedef logic [15:0][31:0] blk_words_t;

  localparam logic [7:0]  PAD_MARKER    = 8'h80;
  localparam int unsigned LEN_FIELD_OFS = 56;
  localparam int unsigned BLK_BYTES     = 64;

  // Byte k of a block lands in word k/4, most significant lane first.
  function automatic blk_words_t put_byte(input blk_words_t w, input logic [5:0] idx,
                                          input logic [7:0] b);
    blk_words_t r;
    r = w;
    r[idx[5:2]][{~idx[1:0], 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic blk_words_t put_len(input blk_words_t w, input logic [63:0] bits);
    blk_words_t r;
    r = w;
    r[4'(LEN_FIELD_OFS / 4)]     = bits[63:32];
    r[4'(LEN_FIELD_OFS / 4 + 1)] = bits[31:0];
    return r;
  endfunction

endpackage

// File: rtl/sha_padder.sv
// Packs a byte stream into big-endian words, appends SHA-256 padding and the
// 64-bit bit length, and presents 512-bit blocks on a valid/ready handshake.
module sha_padder
  import sha_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              blk_valid,
  output logic [15:0][31:0] blk_words,
  output logic              blk_last,
  input  logic              blk_ready
);

  state_e             state_q, state_d;
  logic [6:0]         byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]   msg_len_q, msg_len_d;
  blk_words_t         buf_q, buf_d;
  logic               last_q, last_d;
  logic               extra_q, extra_d;
  logic               marker_q, marker_d;
  logic               in_ready_q, in_ready_d;
  logic               blk_valid_q, blk_valid_d;
  logic               blk_last_q, blk_last_d;
  logic [63:0]        len_bits_s;

  assign len_bits_s = 64'(msg_len_q) << 3;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    msg_len_d  = msg_len_q;
    buf_d      = buf_q;
    last_d     = last_q;
    extra_d    = extra_q;
    marker_d   = marker_q;
    case (state_q)
      FILL: begin
        if (in_valid && in_ready_q) begin
          buf_d      = put_byte(buf_q, byte_cnt_q[5:0], in_data);
          byte_cnt_d = byte_cnt_q + 7'd1;
          msg_len_d  = msg_len_q + LEN_W'(1);
          if (in_last) begin
            state_d = PAD;
          end else if (byte_cnt_q == 7'(BLK_BYTES - 1)) begin
            state_d  = EMIT;
            last_d   = 1'b0;
            extra_d  = 1'b0;
            marker_d = 1'b0;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      PAD: begin
        // A final byte that fills the block defers the marker to the next block.
        if (byte_cnt_q == 7'(BLK_BYTES)) begin
          marker_d = 1'b1;
          last_d   = 1'b0;
        end else begin
          buf_d = put_byte(buf_q, byte_cnt_q[5:0], PAD_MARKER);
          if (byte_cnt_q < 7'(LEN_FIELD_OFS)) begin
            buf_d  = put_len(buf_d, len_bits_s);
            last_d = 1'b1;
          end else begin
            extra_d = 1'b1;
            last_d  = 1'b0;
          end
        end
        state_d = EMIT;
      end
      EMIT: begin
        if (blk_ready) begin
          buf_d      = '0;
          byte_cnt_d = 7'd0;
          if (last_q) begin
            msg_len_d = '0;
          end else begin
            msg_len_d = msg_len_q;
          end
          state_d = (extra_q || marker_q) ? EXTRA : FILL;
        end else begin
          state_d = EMIT;
        end
      end
      EXTRA: begin
        buf_d = put_len(buf_q, len_bits_s);
        if (marker_q) begin
          buf_d = put_byte(buf_d, 6'd0, PAD_MARKER);
        end else begin
          buf_d = buf_d;
        end
        extra_d  = 1'b0;
        marker_d = 1'b0;
        last_d   = 1'b1;
        state_d  = EMIT;
      end
      default: begin
        state_d = FILL;
      end
    endcase
    in_ready_d  = (state_d == FILL);
    blk_valid_d = (state_d == EMIT);
    blk_last_d  = (state_d == EMIT) && last_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      byte_cnt_q  <= 7'd0;
      msg_len_q   <= '0;
      buf_q       <= '0;
      last_q      <= 1'b0;
      extra_q     <= 1'b0;
      marker_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      msg_len_q   <= msg_len_d;
      buf_q       <= buf_d;
      last_q      <= last_d;
      extra_q     <= extra_d;
      marker_q    <= marker_d;
      in_ready_q  <= in_ready_d;
      blk_valid_q <= blk_valid_d;
      blk_last_q  <= blk_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_words = buf_q;
  assign blk_last  = blk_last_q;

endmodule

// File: tb/tb_sha_padder.sv
// Bench for sha_padder: directed vector table, hand-written corner sequences and
// randomized messages checked against a byte-level SHA-256 padding model.
module tb_sha_padder;
  import sha_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          len;
    int          pat;
    int          blk;
    int          word;
    logic [31:0] exp_word;
    logic        exp_last;
    int          exp_nblk;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready, blk_valid, blk_last, blk_ready;
  blk_words_t blk_words;

  bit   ready_rand = 1'b0;
  logic ready_man  = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  blk_words_t got_w[$], exp_w[$];
  logic       got_l[$], exp_l[$];
  bq_t        msg_q;
  vec_t       vecs[10];

  always #5 clk = ~clk;

  sha_padder #(.LEN_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .blk_valid(blk_valid), .blk_words(blk_words),
    .blk_last(blk_last), .blk_ready(blk_ready)
  );

  always @(negedge clk) blk_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_man;

  // Record every block that will be taken on the coming rising edge.
  always @(negedge clk) begin
    #1;
    if (rst && blk_valid && blk_ready) begin
      got_w.push_back(blk_words);
      got_l.push_back(blk_last);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  // Reference: standard SHA-256 padding built as a byte list, then cut into blocks.
  task automatic build_expected(input bq_t m);
    bq_t         p;
    logic [63:0] bits;
    blk_words_t  w;
    int          nb;
    exp_w.delete();
    exp_l.delete();
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 16; j++)
        w[j] = {p[64*b+4*j], p[64*b+4*j+1], p[64*b+4*j+2], p[64*b+4*j+3]};
      exp_w.push_back(w);
      exp_l.push_back(b == nb - 1);
    end
  endtask

  task automatic make_msg(input int len, input int pat);
    msg_q.delete();
    for (int i = 0; i < len; i++) begin
      case (pat)
        0:       msg_q.push_back(8'h61 + 8'(i));
        1:       msg_q.push_back(8'h00);
        default: msg_q.push_back(8'(i));
      endcase
    end
  endtask

  task automatic send_msg(input bq_t m, input bit gaps, input bit with_last);
    int guard;
    @(negedge clk);
    for (int i = 0; i < m.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = m[i];
      in_last  = with_last && (i == m.size() - 1);
      guard = 0;
      #1;
      while (!in_ready && guard < 1000) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_blocks(input int n);
    int guard;
    guard = 0;
    while (got_w.size() < n && guard < 2000) begin
      @(negedge clk);
      #2;
      guard++;
    end
    chk("blk_timeout", got_w.size() >= n, 1);
  endtask

  task automatic clear_got();
    got_w.delete();
    got_l.delete();
  endtask

  initial begin
    int         lens[12];
    int         len;
    int         guard;
    blk_words_t tmp;

    vecs[0] = '{3,  0, 0, 0,  32'h61626380, 1'b1, 1};
    vecs[1] = '{3,  0, 0, 15, 32'h00000018, 1'b1, 1};
    vecs[2] = '{55, 1, 0, 13, 32'h00000080, 1'b1, 1};
    vecs[3] = '{55, 1, 0, 15, 32'h000001B8, 1'b1, 1};
    vecs[4] = '{56, 1, 0, 14, 32'h80000000, 1'b0, 2};
    vecs[5] = '{56, 1, 1, 15, 32'h000001C0, 1'b1, 2};
    vecs[6] = '{64, 2, 0, 0,  32'h00010203, 1'b0, 2};
    vecs[7] = '{64, 2, 0, 15, 32'h3C3D3E3F, 1'b0, 2};
    vecs[8] = '{64, 2, 1, 0,  32'h80000000, 1'b1, 2};
    vecs[9] = '{64, 2, 1, 15, 32'h00000200, 1'b1, 2};
    lens = '{1, 54, 55, 56, 57, 62, 63, 64, 65, 119, 120, 128};

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_blk_last", blk_last, 0);
    chk("rst_blk_words", blk_words, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      make_msg(vecs[i].len, vecs[i].pat);
      clear_got();
      send_msg(msg_q, 1'b0, 1'b1);
      wait_blocks(vecs[i].exp_nblk);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_nblk", i), got_w.size(), vecs[i].exp_nblk);
      if (vecs[i].blk < got_w.size()) begin
        tmp = got_w[vecs[i].blk];
        chk($sformatf("vec%0d_word", i), tmp[vecs[i].word], vecs[i].exp_word);
        chk($sformatf("vec%0d_last", i), got_l[vecs[i].blk], vecs[i].exp_last);
      end else begin
        chk($sformatf("vec%0d_missing", i), got_w.size(), vecs[i].blk + 1);
      end
    end

    // Latency: one pad cycle, then the block is valid
    make_msg(3, 0);
    clear_got();
    send_msg(msg_q, 1'b0, 1'b1);
    #1;
    chk("lat_pad_cycle", blk_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_emit_cycle", blk_valid, 1);
    wait_blocks(1);

    // Backpressure: block held stable, input stalled
    @(posedge clk);
    #1;
    ready_man = 1'b0;
    make_msg(3, 0);
    build_expected(msg_q);
    clear_got();
    send_msg(msg_q, 1'b0, 1'b1);
    guard = 0;
    #1;
    while (!blk_valid && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid%0d", c), blk_valid, 1);
      chk($sformatf("bp_words%0d", c), blk_words, exp_w[0]);
      chk($sformatf("bp_last%0d", c), blk_last, 1);
      chk($sformatf("bp_in_ready%0d", c), in_ready, 0);
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    ready_man = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_valid", blk_valid, 0);
    chk("bp_release_count", got_w.size(), 1);
    make_msg(3, 0);
    build_expected(msg_q);
    clear_got();
    send_msg(msg_q, 1'b0, 1'b1);
    wait_blocks(1);
    if (got_w.size() > 0) chk("bp_after_block", got_w[0], exp_w[0]);
    else chk("bp_after_missing", got_w.size(), 1);

    // Asynchronous reset mid-message discards the partial block
    msg_q.delete();
    for (int i = 0; i < 10; i++) msg_q.push_back(8'hA5);
    clear_got();
    send_msg(msg_q, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_words", blk_words, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_valid", blk_valid, 0);
    chk("mid_rst_last", blk_last, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    make_msg(3, 0);
    build_expected(msg_q);
    clear_got();
    send_msg(msg_q, 1'b0, 1'b1);
    wait_blocks(1);
    repeat (2) @(negedge clk);
    chk("mid_rst_nblk", got_w.size(), 1);
    if (got_w.size() > 0) begin
      chk("mid_rst_block", got_w[0], exp_w[0]);
      chk("mid_rst_blk_last", got_l[0], 1);
    end else begin
      chk("mid_rst_missing", got_w.size(), 1);
    end

    // Randomized messages with input gaps and random consumer stalls
    ready_rand = 1'b1;
    for (int t = 0; t < 24; t++) begin
      len = (t < 12) ? lens[t] : int'($urandom_range(1, 200));
      msg_q.delete();
      for (int k = 0; k < len; k++) msg_q.push_back(8'($urandom_range(0, 255)));
      build_expected(msg_q);
      clear_got();
      send_msg(msg_q, 1'b1, 1'b1);
      wait_blocks(exp_w.size());
      repeat (4) @(negedge clk);
      chk($sformatf("rnd%0d_len%0d_nblk", t, len), got_w.size(), exp_w.size());
      for (int b = 0; b < exp_w.size() && b < got_w.size(); b++) begin
        chk($sformatf("rnd%0d_blk%0d_words", t, b), got_w[b], exp_w[b]);
        chk($sformatf("rnd%0d_blk%0d_last", t, b), got_l[b], exp_l[b]);
      end
    end
    ready_rand = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha_padder.md
Name: sha_padder

Overview:
- Message front end for the SHA-256 core: accepts a byte stream and packs it into big-endian 32-bit words.
- Appends SHA-256 padding: a 0x80 marker, zero fill, and the 64-bit message bit length.
- Presents complete 512-bit blocks as 16 words on a valid/ready handshake.
- Sits upstream of the compression transform; the integration layer converts blk_valid/blk_ready into the transform's start/status handshake and feeds blk_words into its 16-word block input.

Parameters:
- LEN_W, 32, width of the internal message byte counter; messages up to 2^LEN_W-1 bytes.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  8  message byte.
- in_last  in  1  qualifies in_data as the final byte of the message.
- in_ready  out  1  padder accepts a byte this cycle.
- blk_valid  out  1  blk_words holds a complete block.
- blk_words  out  32 x [16]  block words; word 0 is the first 4 message bytes.
- blk_last  out  1  this block is the final block of the message.
- blk_ready  in  1  consumer takes the block this cycle.

Behaviour:
- Reset (rst low, async): state=FILL, byte_cnt=0, msg_len=0, buffer all zero.
  - Outputs on reset: in_ready=1, blk_valid=0, blk_last=0, blk_words all 0.
  - A reset asserted mid-message or mid-emit discards everything; no partial block is emitted afterwards.
- Byte transfer: occurs when in_valid && in_ready.
  - Byte k of a block (k = 0..63) goes to word k/4, bits [31-8*(k%4) -: 8].
  - byte_cnt and msg_len each increment by 1 per transfer.
- States:
  - FILL: in_ready=1.
    - Transfer with byte_cnt==63 and !in_last -> EMIT, pad_pending=0, last_pending=0.
    - Transfer with in_last -> PAD.
    - Other transfers stay in FILL.
  - PAD (1 cycle): in_ready=0. Let p = byte_cnt after the final transfer.
    - p<=55: byte p=0x80, bytes p+1..55=0, bytes 56..63 = msg_len*8 as 64-bit big-endian (upper bits zero-extended) -> EMIT with last=1.
    - 56<=p<=63: byte p=0x80, bytes p+1..63=0 -> EMIT with last=0, set extra_pending.
    - p==64 (in_last filled the block): no write -> EMIT with last=0, set marker_pending.
  - EMIT: blk_valid=1, blk_last=registered last flag, in_ready=0.
    - blk_words and blk_last are held stable until blk_ready.
    - On handshake: clear buffer, byte_cnt=0, then go to EXTRA if extra_pending or marker_pending, else FILL.
    - If the emitted block had last=1, also clear msg_len.
  - EXTRA (1 cycle): build the final block.
    - Byte 0=0x80 if marker_pending, else 0.
    - Remaining bytes up to 55 = 0; bytes 56..63 = length.
    - Clear both pending flags -> EMIT with last=1.
- Throughput and latency:
  - One byte per cycle in FILL.
  - In-last transfer to blk_valid: 2 cycles (PAD then EMIT).
  - Full non-last block: blk_valid the cycle after byte 63.
- blk_ready while blk_valid=0 is ignored. in_valid while in_ready=0 is ignored; the source must hold the byte.
- Zero-length messages are not supported; every message carries at least one byte with in_last.
- msg_len wraps modulo 2^LEN_W; exceeding the limit is a usage error and is not flagged.

Decomposition:
- Package sha_pkg holds:
  - the state enum typedef (FILL, PAD, EMIT, EXTRA);
  - the block-word array typedef (16 x 32 bits);
  - constants PAD_MARKER=8'h80, LEN_FIELD_OFS=56, BLK_BYTES=64.
- No sub-module is needed. The byte-lane write (byte index to word/lane select) is a function in sha_pkg, reused by the padding logic.

Test Plan:
- "abc" (0x61,0x62,0x63, in_last on 0x63), blk_ready=1 -> one block:
  - W0=0x61626380, W1..W14=0, W15=0x00000018, blk_last=1;
  - blk_valid 2 cycles after the last byte.
- 55 bytes of 0x00 -> one block:
  - W13=0x00000080, W14=0, W15=0x000001B8, blk_last=1.
- 56 bytes of 0x00 -> two blocks:
  - block 1: W14=0x80000000, W15=0, blk_last=0;
  - block 2: W0..W14=0, W15=0x000001C0, blk_last=1.
- 64 bytes 0x00..0x3F -> two blocks:
  - block 1: W0=0x00010203, W15=0x3C3D3E3F, blk_last=0;
  - block 2: W0=0x80000000, W15=0x00000200, blk_last=1.
- Backpressure: hold blk_ready=0 for 5 cycles during EMIT -> blk_words/blk_last stable, in_ready=0 and in_valid bytes not accepted; release -> single handshake, in_ready=1 next cycle.
- Reset mid-message: 10 bytes accepted, pull rst low async for 2 cycles -> outputs at reset values immediately; then send "abc" -> same result as the first scenario (W15=0x18, not polluted by the 10 earlier bytes).
